// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial pattern transmitter. A start request captures an PAT_W-bit pattern
//   and a repeat count. The pattern is then sent MSB-first on x_out, once per
//   copy, with GAP_CYC idle cycles between copies. A one-cycle done pulse
//   marks the end of the request.
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous reset, active-high
//     start    transfer request, sampled only in IDLE
//     pat_in   pattern, captured when start is accepted
//     rep_cnt  number of copies, captured when start is accepted
//     x_out    serial data, 0 whenever x_valid=0
//     x_valid  x_out carries a pattern bit this cycle
//     busy     transfer in progress (SHIFT/GAP)
//     done     one-cycle pulse after the last bit of the request
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | a pattern bit is on x_out
//   GAP   | idle gap between two copies
//   DONE  | done pulse, returns to IDLE
module seq_pattern_tx #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q, pat_nxt;
  // sh[PAT_W-1] is always the bit currently driven on x_out
  logic [PAT_W-1:0] sh, sh_nxt;
  // bits still to send after the current one in this copy
  logic [BW-1:0]    bit_cnt, bit_nxt;
  // copies still to send, including the current one
  logic [CNT_W-1:0] copy_cnt, copy_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic             xo_nxt, xv_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      copy_cnt <= '0;
      gap_cnt  <= '0;
      x_out    <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pat_q    <= pat_nxt;
      sh       <= sh_nxt;
      bit_cnt  <= bit_nxt;
      copy_cnt <= copy_nxt;
      gap_cnt  <= gap_nxt;
      x_out    <= xo_nxt;
      x_valid  <= xv_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Outputs are computed for the next state so they come straight from flops
  // and line up with the state register.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_q;
    sh_nxt    = sh;
    bit_nxt   = bit_cnt;
    copy_nxt  = copy_cnt;
    gap_nxt   = gap_cnt;
    xo_nxt    = 1'b0;
    xv_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (rep_cnt != '0) begin
            state_nxt = SHIFT;
            pat_nxt   = pat_in;
            sh_nxt    = pat_in;
            bit_nxt   = BW'(PAT_W - 1);
            copy_nxt  = rep_cnt;
            xo_nxt    = pat_in[PAT_W-1];
            xv_nxt    = 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (bit_cnt != '0) begin
          sh_nxt   = {sh[PAT_W-2:0], 1'b0};
          bit_nxt  = bit_cnt - BW'(1);
          xo_nxt   = sh[PAT_W-2];
          xv_nxt   = 1'b1;
          busy_nxt = 1'b1;
        end else begin
          copy_nxt = copy_cnt - CNT_W'(1);
          if (copy_cnt == CNT_W'(1)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (GAP_CYC > 0) begin
            state_nxt = GAP;
            gap_nxt   = GW'(GAP_CYC - 1);
            busy_nxt  = 1'b1;
          end else begin
            sh_nxt   = pat_q;
            bit_nxt  = BW'(PAT_W - 1);
            xo_nxt   = pat_q[PAT_W-1];
            xv_nxt   = 1'b1;
            busy_nxt = 1'b1;
          end
        end
      end

      GAP: begin
        busy_nxt = 1'b1;
        if (gap_cnt == '0) begin
          state_nxt = SHIFT;
          sh_nxt    = pat_q;
          bit_nxt   = BW'(PAT_W - 1);
          xo_nxt    = pat_q[PAT_W-1];
          xv_nxt    = 1'b1;
        end else begin
          gap_nxt = gap_cnt - GW'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
